// File: rtl/mmind_pkg.sv
// Mastermind shared definitions: code geometry, guess limit, FSM state encodings.
package mmind_pkg;

    localparam int WIDTH       = 8;
    localparam int CW          = $clog2(WIDTH);
    localparam int MAX_GUESSES = 10;
    localparam int GUESS_W     = 4;

    // Control FSM encodings; the FSM and benches share these.
    typedef enum logic [1:0] {
        INIT    = 2'b00,
        CAPTURE = 2'b01,
        WAIT    = 2'b11,
        COMPARE = 2'b10
    } mmind_state_e;

endpackage

// File: rtl/mmind_if.sv
// FSM <-> datapath bundle: switch bank, control strobes, and datapath status.
interface mmind_if;
    import mmind_pkg::*;

    logic [WIDTH-1:0]   sw;
    logic               ans_en;
    logic               swcnt_clr;
    logic               swcnt_en;
    logic               corr_clr;
    logic               corr_en;
    logic [CW-1:0]      swcnt;
    logic [CW:0]        corr;
    logic [CW:0]        result;
    logic               result_vld;
    logic               win;
    logic [GUESS_W-1:0] guesses;
    logic               game_over;

    // FSM side drives controls and reads status.
    modport master (
        output sw, ans_en, swcnt_clr, swcnt_en, corr_clr, corr_en,
        input  swcnt, corr, result, result_vld, win, guesses, game_over
    );

    // Datapath side.
    modport slave (
        input  sw, ans_en, swcnt_clr, swcnt_en, corr_clr, corr_en,
        output swcnt, corr, result, result_vld, win, guesses, game_over
    );

endinterface

// File: rtl/mmind_counter.sv
// Sync up-counter, clear beats enable; at MAX it either wraps to 0 or holds.
module mmind_counter #(
    parameter int W   = 3,
    parameter int MAX = 7,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    // Count with clear priority; terminal value wraps or saturates.
    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= '0;
        else if (en) begin
            if (q == MAXV)
                q <= SAT ? MAXV : '0;
            else
                q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/mmind_datapath.sv
// Mastermind datapath: answer/guess registers, bit index, match counter,
// per-guess result and guess count. Optional guess limit: MMIND_GUESS_LIMIT_EN.
module mmind_datapath
    import mmind_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    mmind_if.slave bus
);

    logic [WIDTH-1:0]   ans;
    logic [WIDTH-1:0]   guess_q;
    logic [CW-1:0]      swcnt_q;
    logic [CW:0]        corr_q;
    logic [GUESS_W-1:0] guesses_q;
    logic [CW:0]        result_q;
    logic               result_vld_q;
    logic               win_q;
    logic               game_over_q;
    logic               corr_en_q;
    logic               corr_en_eff;
    logic               match;
    logic               done;

`ifdef MMIND_GUESS_LIMIT_EN
    assign corr_en_eff = bus.corr_en & ~game_over_q;
`else
    assign corr_en_eff = bus.corr_en;
`endif

    assign match = (guess_q[swcnt_q] == ans[swcnt_q]);
    // Falling edge of the compare strobe closes a pass; an answer load wins.
    assign done  = corr_en_q & ~corr_en_eff & ~bus.ans_en;

    mmind_counter #(.W(CW), .MAX(WIDTH-1), .SAT(1'b0)) u_swcnt (
        .clk(clk), .reset(reset), .clr(bus.swcnt_clr), .en(bus.swcnt_en), .q(swcnt_q)
    );

    mmind_counter #(.W(CW+1), .MAX(WIDTH), .SAT(1'b1)) u_corr (
        .clk(clk), .reset(reset), .clr(bus.corr_clr), .en(corr_en_eff & match), .q(corr_q)
    );

    mmind_counter #(.W(GUESS_W), .MAX(15), .SAT(1'b1)) u_guesses (
        .clk(clk), .reset(reset), .clr(bus.ans_en), .en(done), .q(guesses_q)
    );

    // Answer load and guess snapshot; the snapshot isolates the compare from switch motion.
    always_ff @(posedge clk) begin
        if (reset) begin
            ans     <= '0;
            guess_q <= '0;
        end else begin
            if (bus.ans_en)   ans     <= bus.sw;
            if (bus.corr_clr) guess_q <= bus.sw;
        end
    end

    // Compare strobe delay for completion edge detection.
    always_ff @(posedge clk) begin
        if (reset) corr_en_q <= 1'b0;
        else       corr_en_q <= corr_en_eff;
    end

    // Publish the result of a finished pass; answer load clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q     <= '0;
            result_vld_q <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            result_vld_q <= 1'b0;
            if (bus.ans_en) begin
                result_q <= '0;
                win_q    <= 1'b0;
            end else if (done) begin
                result_q     <= corr_q;
                result_vld_q <= 1'b1;
                win_q        <= (corr_q == (CW+1)'(WIDTH));
            end
        end
    end

`ifdef MMIND_GUESS_LIMIT_EN
    // Sticky: the losing pass that reaches the limit ends the game.
    always_ff @(posedge clk) begin
        if (reset || bus.ans_en)
            game_over_q <= 1'b0;
        else if (done && guesses_q == GUESS_W'(MAX_GUESSES-1) && corr_q != (CW+1)'(WIDTH))
            game_over_q <= 1'b1;
    end
`else
    assign game_over_q = 1'b0;
`endif

    assign bus.swcnt      = swcnt_q;
    assign bus.corr       = corr_q;
    assign bus.result     = result_q;
    assign bus.result_vld = result_vld_q;
    assign bus.win        = win_q;
    assign bus.guesses    = guesses_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_mmind_datapath.sv
// Directed bench for mmind_datapath; limit checks follow MMIND_GUESS_LIMIT_EN.
module tb_mmind_datapath;
    import mmind_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    mmind_if bus();

    mmind_datapath dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ans_en    = 1'b0;
        bus.swcnt_clr = 1'b0;
        bus.swcnt_en  = 1'b0;
        bus.corr_clr  = 1'b0;
        bus.corr_en   = 1'b0;
    endtask

    task automatic load_ans(input logic [WIDTH-1:0] v);
        bus.sw = v;
        bus.ans_en = 1'b1;
        tick();
        bus.ans_en = 1'b0;
    endtask

    // One full FSM-style pass; returns status sampled in the cycle after corr_en drops.
    task automatic run_guess(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] sw_during,
                             output logic vld, output logic [CW:0] res);
        bus.sw = g;
        bus.corr_clr = 1'b1;
        bus.swcnt_clr = 1'b1;
        tick();
        bus.corr_clr = 1'b0;
        bus.swcnt_clr = 1'b0;
        bus.sw = sw_during;
        bus.swcnt_en = 1'b1;
        bus.corr_en = 1'b1;
        repeat (WIDTH) tick();
        bus.swcnt_en = 1'b0;
        bus.corr_en = 1'b0;
        tick();
        vld = bus.result_vld;
        res = bus.result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sw = '0;
        idle();
        repeat (2) tick();
        reset = 1'b0;
        n_chk++; if ({bus.swcnt, bus.corr, bus.result} !== '0) begin n_fail++;
            $display("FAIL reset_counts: got swcnt=%0d corr=%0d result=%0d, expected 0", bus.swcnt, bus.corr, bus.result); end
        n_chk++; if ({bus.result_vld, bus.win, bus.guesses, bus.game_over} !== '0) begin n_fail++;
            $display("FAIL reset_flags: got vld=%b win=%b guesses=%0d go=%b, expected 0", bus.result_vld, bus.win, bus.guesses, bus.game_over); end
    endtask

    task automatic test_match();
        logic vld; logic [CW:0] res;
        load_ans(8'hA5);
        run_guess(8'hA5, 8'hA5, vld, res);
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL match_vld: got %b expected 1", vld); end
        n_chk++; if (res !== 4'd8) begin n_fail++; $display("FAIL match_result: got %0d expected 8", res); end
        n_chk++; if (bus.win !== 1'b1) begin n_fail++; $display("FAIL match_win: got %b expected 1", bus.win); end
        n_chk++; if (bus.guesses !== 4'd1) begin n_fail++; $display("FAIL match_guesses: got %0d expected 1", bus.guesses); end
        n_chk++; if (bus.swcnt !== 3'd0) begin n_fail++; $display("FAIL match_swcnt_wrap: got %0d expected 0", bus.swcnt); end
        tick();
        n_chk++; if (bus.result_vld !== 1'b0) begin n_fail++; $display("FAIL match_vld_pulse: got %b expected 0", bus.result_vld); end
        n_chk++; if (bus.result !== 4'd8) begin n_fail++; $display("FAIL match_result_hold: got %0d expected 8", bus.result); end
    endtask

    task automatic test_mismatch();
        logic vld; logic [CW:0] res;
        run_guess(8'h5A, 8'h5A, vld, res);
        n_chk++; if (res !== 4'd0) begin n_fail++; $display("FAIL inverse_result: got %0d expected 0", res); end
        n_chk++; if (bus.win !== 1'b0) begin n_fail++; $display("FAIL inverse_win: got %b expected 0", bus.win); end
        run_guess(8'hA4, 8'hA4, vld, res);
        n_chk++; if (res !== 4'd7) begin n_fail++; $display("FAIL onebit_result: got %0d expected 7", res); end
        n_chk++; if (bus.guesses !== 4'd3) begin n_fail++; $display("FAIL onebit_guesses: got %0d expected 3", bus.guesses); end
    endtask

    task automatic test_snapshot();
        logic vld; logic [CW:0] res;
        load_ans(8'hF0);
        n_chk++; if ({bus.result, bus.win, bus.guesses} !== '0) begin n_fail++;
            $display("FAIL ans_clear: got result=%0d win=%b guesses=%0d expected 0", bus.result, bus.win, bus.guesses); end
        run_guess(8'hF0, 8'h00, vld, res);
        n_chk++; if (res !== 4'd8) begin n_fail++; $display("FAIL snapshot_result: got %0d expected 8", res); end
        n_chk++; if (bus.win !== 1'b1) begin n_fail++; $display("FAIL snapshot_win: got %b expected 1", bus.win); end
    endtask

    task automatic test_wrap();
        bus.swcnt_clr = 1'b1; tick(); bus.swcnt_clr = 1'b0;
        bus.swcnt_en = 1'b1;
        repeat (7) tick();
        n_chk++; if (bus.swcnt !== 3'd7) begin n_fail++; $display("FAIL wrap_at7: got %0d expected 7", bus.swcnt); end
        tick();
        n_chk++; if (bus.swcnt !== 3'd0) begin n_fail++; $display("FAIL wrap_to0: got %0d expected 0", bus.swcnt); end
        repeat (3) tick();
        bus.swcnt_clr = 1'b1;
        tick();
        n_chk++; if (bus.swcnt !== 3'd0) begin n_fail++; $display("FAIL clr_priority: got %0d expected 0", bus.swcnt); end
        idle();
    endtask

    task automatic test_ans_vs_done();
        // win=1, guesses=1 from the previous pass; drop corr_en with ans_en asserted.
        bus.sw = 8'hF0;
        bus.corr_clr = 1'b1; tick(); bus.corr_clr = 1'b0;
        bus.corr_en = 1'b1;
        repeat (WIDTH) tick();
        bus.corr_en = 1'b0;
        bus.sw = 8'h3C;
        bus.ans_en = 1'b1;
        tick();
        bus.ans_en = 1'b0;
        n_chk++; if (bus.result_vld !== 1'b0) begin n_fail++; $display("FAIL concur_vld: got %b expected 0", bus.result_vld); end
        n_chk++; if ({bus.result, bus.win, bus.guesses} !== '0) begin n_fail++;
            $display("FAIL concur_clear: got result=%0d win=%b guesses=%0d expected 0", bus.result, bus.win, bus.guesses); end
        tick();
        n_chk++; if (bus.result_vld !== 1'b0) begin n_fail++; $display("FAIL concur_late_vld: got %b expected 0", bus.result_vld); end
    endtask

    task automatic test_limit();
        logic vld; logic [CW:0] res;
        int nvld = 0;
        load_ans(8'hFF);
        for (int i = 0; i < MAX_GUESSES; i++) begin
            run_guess(8'h00, 8'h00, vld, res);
            if (vld === 1'b1 && res === 4'd0) nvld++;
            if (i == MAX_GUESSES-2) begin
                n_chk++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL limit_early_go: got %b expected 0", bus.game_over); end
            end
        end
        n_chk++; if (nvld != MAX_GUESSES) begin n_fail++; $display("FAIL limit_vld_count: got %0d expected %0d", nvld, MAX_GUESSES); end
        n_chk++; if (bus.guesses !== 4'(MAX_GUESSES)) begin n_fail++; $display("FAIL limit_guesses: got %0d expected %0d", bus.guesses, MAX_GUESSES); end
`ifdef MMIND_GUESS_LIMIT_EN
        n_chk++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL limit_go_set: got %b expected 1", bus.game_over); end
        run_guess(8'h00, 8'h00, vld, res);
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL limit_suppress_vld: got %b expected 0", vld); end
        n_chk++; if (bus.guesses !== 4'(MAX_GUESSES)) begin n_fail++; $display("FAIL limit_hold_guesses: got %0d expected %0d", bus.guesses, MAX_GUESSES); end
`else
        n_chk++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL nolimit_go: got %b expected 0", bus.game_over); end
        run_guess(8'h00, 8'h00, vld, res);
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL nolimit_vld: got %b expected 1", vld); end
        n_chk++; if (bus.guesses !== 4'(MAX_GUESSES+1)) begin n_fail++; $display("FAIL nolimit_guesses: got %0d expected %0d", bus.guesses, MAX_GUESSES+1); end
`endif
        load_ans(8'hFF);
        n_chk++; if ({bus.game_over, bus.guesses} !== '0) begin n_fail++;
            $display("FAIL limit_ans_clear: got go=%b guesses=%0d expected 0", bus.game_over, bus.guesses); end
    endtask

    task automatic test_reset_mid();
        logic vld; logic [CW:0] res;
        int seen = 0;
        run_guess(8'hFF, 8'hFF, vld, res);   // guesses=1, win=1 before the abort
        bus.sw = 8'hFF;
        bus.corr_clr = 1'b1; bus.swcnt_clr = 1'b1; tick();
        bus.corr_clr = 1'b0; bus.swcnt_clr = 1'b0;
        bus.corr_en = 1'b1; bus.swcnt_en = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        idle();
        tick();
        reset = 1'b0;
        n_chk++; if ({bus.swcnt, bus.corr, bus.result} !== '0) begin n_fail++;
            $display("FAIL abort_counts: got swcnt=%0d corr=%0d result=%0d expected 0", bus.swcnt, bus.corr, bus.result); end
        n_chk++; if ({bus.result_vld, bus.win, bus.guesses, bus.game_over} !== '0) begin n_fail++;
            $display("FAIL abort_flags: got vld=%b win=%b guesses=%0d go=%b expected 0", bus.result_vld, bus.win, bus.guesses, bus.game_over); end
        repeat (3) begin tick(); if (bus.result_vld === 1'b1) seen++; end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_vld: got %0d pulses expected 0", seen); end
        // Answer was cleared too: an all-zero guess now matches everywhere.
        run_guess(8'h00, 8'h00, vld, res);
        n_chk++; if (res !== 4'd8) begin n_fail++; $display("FAIL abort_ans_zero: got %0d expected 8", res); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_snapshot();
        test_wrap();
        test_ans_vs_done();
        test_limit();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
